// File: rtl/paddle_pkg.sv
// Shared constants and saturating position arithmetic for the AY-3-8500 paddle emulation.
package paddle_pkg;

   localparam int POS_W_DEF       = 8;
   localparam int POS_INIT_DEF    = 128;
   localparam int POS_MAX_DEF     = 255;
   localparam int SPEED_SLOW_DEF  = 5;
   localparam int SPEED_FAST_DEF  = 8;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Position moves by step towards 0 (up) or max_pos (down). The extra bit catches
   // borrow/carry so the result clamps instead of wrapping.
   function automatic logic [POS_W_DEF-1:0] sat_step(
      input logic [POS_W_DEF-1:0] pos,
      input logic [POS_W_DEF-1:0] step,
      input dir_e                 dir,
      input logic [POS_W_DEF-1:0] max_pos
   );
      logic [POS_W_DEF:0] wide;
      logic [POS_W_DEF-1:0] res;
      if (dir == DIR_UP) begin
         wide = {1'b0, pos} - {1'b0, step};
         res  = wide[POS_W_DEF] ? '0 : wide[POS_W_DEF-1:0];
      end else begin
         wide = {1'b0, pos} + {1'b0, step};
         res  = (wide > {1'b0, max_pos}) ? max_pos : wide[POS_W_DEF-1:0];
      end
      sat_step = res;
   endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle: position register updated once per frame, and a capture counter that
// holds the pin low for 'pos' lines after each frame edge.
module paddle_channel
   import paddle_pkg::*;
#(
   parameter int POS_W    = POS_W_DEF,
   parameter int POS_INIT = POS_INIT_DEF,
   parameter int POS_MAX  = POS_MAX_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             frame_edge,
   input  logic             line_edge,
   input  logic             recentre,
   input  logic             up,
   input  logic             down,
   input  logic [POS_W-1:0] step,
   output logic [POS_W-1:0] pos,
   output logic             pin
);

   logic [POS_W-1:0] cap;
   logic [POS_W-1:0] pos_next;

   // Up wins over down when both are held.
   always_comb begin
      pos_next = pos;
      if (recentre)
         pos_next = POS_W'(POS_INIT);
      else if (up)
         pos_next = sat_step(pos, step, DIR_UP, POS_W'(POS_MAX));
      else if (down)
         pos_next = sat_step(pos, step, DIR_DOWN, POS_W'(POS_MAX));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos <= POS_W'(POS_INIT);
         cap <= '0;
      end else if (!enable) begin
         cap <= '0;
      end else if (frame_edge) begin
         cap <= pos;
         pos <= pos_next;
      end else if (line_edge && (cap != '0)) begin
         cap <= cap - 1'b1;
      end
   end

   assign pin = (cap == '0);

endmodule

// File: rtl/paddle_ramp_gen.sv
// Paddle input emulation for the ay38500: synchronises HSync/VSync into clk, detects
// their rising edges and drives two paddle channels.
module paddle_ramp_gen
   import paddle_pkg::*;
#(
   parameter int POS_W       = POS_W_DEF,
   parameter int POS_INIT    = POS_INIT_DEF,
   parameter int POS_MAX     = POS_MAX_DEF,
   parameter int SPEED_SLOW  = SPEED_SLOW_DEF,
   parameter int SPEED_FAST  = SPEED_FAST_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             enable,
   input  logic             fast,
   input  logic             recentre,
   input  logic             p1_up,
   input  logic             p1_down,
   input  logic             p2_up,
   input  logic             p2_down,
   output logic             lp_in,
   output logic             rp_in,
   output logic [POS_W-1:0] p1_pos,
   output logic [POS_W-1:0] p2_pos,
   output logic             frame_tick
);

   logic [SYNC_STAGES-1:0] hs_sync;
   logic [SYNC_STAGES-1:0] vs_sync;
   logic                   hs_prev;
   logic                   vs_prev;
   logic                   hs_edge;
   logic                   vs_edge;
   logic [POS_W-1:0]       step;

   // Edge flags are registered, so a raw edge first sampled at clk edge k reaches
   // the channel registers at edge k+SYNC_STAGES+1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hs_sync <= '0;
         vs_sync <= '0;
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
         hs_edge <= 1'b0;
         vs_edge <= 1'b0;
      end else begin
         hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsync};
         vs_sync <= {vs_sync[SYNC_STAGES-2:0], vsync};
         hs_prev <= hs_sync[SYNC_STAGES-1];
         vs_prev <= vs_sync[SYNC_STAGES-1];
         hs_edge <= hs_sync[SYNC_STAGES-1] & ~hs_prev;
         vs_edge <= vs_sync[SYNC_STAGES-1] & ~vs_prev;
      end
   end

   // frame_tick is a valid-only strobe with no ready: p1_pos/p2_pos carry the new
   // positions from the clk edge that ends the strobe.
   assign frame_tick = vs_edge;
   assign step       = fast ? POS_W'(SPEED_FAST) : POS_W'(SPEED_SLOW);

   paddle_channel #(
      .POS_W    (POS_W),
      .POS_INIT (POS_INIT),
      .POS_MAX  (POS_MAX)
   ) u_ch1 (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .frame_edge (vs_edge),
      .line_edge  (hs_edge),
      .recentre   (recentre),
      .up         (p1_up),
      .down       (p1_down),
      .step       (step),
      .pos        (p1_pos),
      .pin        (lp_in)
   );

   paddle_channel #(
      .POS_W    (POS_W),
      .POS_INIT (POS_INIT),
      .POS_MAX  (POS_MAX)
   ) u_ch2 (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .frame_edge (vs_edge),
      .line_edge  (hs_edge),
      .recentre   (recentre),
      .up         (p2_up),
      .down       (p2_down),
      .step       (step),
      .pos        (p2_pos),
      .pin        (rp_in)
   );

endmodule
